// File: rtl/alu_pkg.sv
// Shared op-code encodings and FSM state type for the multi-cycle ALU.
package alu_pkg;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_MULU = 3'b011;
    localparam logic [2:0] ALU_DIVU = 3'b100;
    localparam logic [2:0] ALU_SLTU = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } alu_state_t;

endpackage

// File: rtl/alu_iter.sv
// Iterative datapath shared by unsigned shift-add multiply and restoring divide.
// {hi,lo} holds product (MULU) or {remainder, quotient} (DIVU); o_res is the next-step value.
module alu_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic               i_div,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_res
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_run;
    logic             r_div;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_m;

    logic [WIDTH:0]     w_madd;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_dsub;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [2*WIDTH-1:0] w_div_next;
    logic               w_last;

    // Multiply: add multiplicand into the upper half when the low bit is set, then shift right.
    assign w_madd     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
    assign w_mul_next = {w_madd, r_lo[WIDTH-1:1]};

    // Divide: shift in the next dividend bit; the borrow bit of the trial subtract decides the quotient bit.
    assign w_shift    = {r_hi, r_lo[WIDTH-1]};
    assign w_dsub     = w_shift - {1'b0, r_m};
    assign w_ge       = ~w_dsub[WIDTH];
    assign w_div_next = {(w_ge ? w_dsub[WIDTH-1:0] : w_shift[WIDTH-1:0]), r_lo[WIDTH-2:0], w_ge};

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
    assign o_done = r_run & w_last;
    assign o_res  = r_div ? w_div_next : w_mul_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_run <= 1'b0;
            r_div <= 1'b0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_m   <= '0;
        end else if (i_start) begin
            r_cnt <= '0;
            r_run <= 1'b1;
            r_div <= i_div;
            r_hi  <= '0;
            r_lo  <= i_div ? i_a : i_b;
            r_m   <= i_div ? i_b : i_a;
        end else if (r_run) begin
            r_cnt        <= r_cnt + CNT_W'(1);
            {r_hi, r_lo} <= o_res;
            if (w_last) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake: single-cycle logic/arith/compare,
// iterative MULU/DIVU via alu_iter, registered outputs held under backpressure.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow
);

    alu_state_t r_state;
    alu_state_t w_state_nxt;

    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_result_hi;
    logic               r_zero;
    logic               r_overflow;

    logic               w_accept;
    logic               w_multi;
    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_res;
    logic [WIDTH-1:0]   w_res_hi;
    logic               w_ovf;
    logic               w_iter_done;
    logic [2*WIDTH-1:0] w_iter_res;

    assign in_ready  = (r_state == IDLE) | ((r_state == DONE) & out_ready);
    assign w_accept  = in_valid & in_ready;
    assign w_multi   = (alu_op == ALU_MULU) | ((alu_op == ALU_DIVU) & (b != '0));
    assign w_sum     = a + b;
    assign w_diff    = a - b;

    assign out_valid = (r_state == DONE);
    assign result    = r_result;
    assign result_hi = r_result_hi;
    assign zero      = r_zero;
    assign overflow  = r_overflow;

    always_comb begin
        w_res    = '0;
        w_res_hi = '0;
        w_ovf    = 1'b0;
        case (alu_op)
            ALU_AND:  w_res = a & b;
            ALU_OR:   w_res = a | b;
            ALU_ADD: begin
                w_res = w_sum;
                w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                w_res = w_diff;
                w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SLTU: w_res = WIDTH'(a < b);
            ALU_SLT:  w_res = WIDTH'($signed(a) < $signed(b));
            // Reached only for b==0; divide-by-zero resolves without iterating.
            ALU_DIVU: begin
                w_res    = '1;
                w_res_hi = a;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = w_multi ? BUSY : DONE;
            BUSY: if (w_iter_done) w_state_nxt = DONE;
            DONE: begin
                if (out_ready) begin
                    if (w_accept) w_state_nxt = w_multi ? BUSY : DONE;
                    else          w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result    <= '0;
            r_result_hi <= '0;
            r_zero      <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_accept && !w_multi) begin
            r_result    <= w_res;
            r_result_hi <= w_res_hi;
            r_zero      <= (w_res == '0);
            r_overflow  <= w_ovf;
        end else if (w_iter_done) begin
            r_result    <= w_iter_res[WIDTH-1:0];
            r_result_hi <= w_iter_res[2*WIDTH-1:WIDTH];
            r_zero      <= (w_iter_res[WIDTH-1:0] == '0);
            r_overflow  <= 1'b0;
        end
    end

    alu_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_accept & w_multi),
        .i_div   (alu_op == ALU_DIVU),
        .i_a     (a),
        .i_b     (b),
        .o_done  (w_iter_done),
        .o_res   (w_iter_res)
    );

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc at WIDTH=32 with hand-computed expectations.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   alu_op = 3'b000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         zero;
    logic         overflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op and wait for out_valid; operands are scrambled after accept.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat, output bit rdy_in_busy);
        lat = 0;
        rdy_in_busy = 1'b0;
        @(negedge clk);
        alu_op = op; a = x; b = y; in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 1) begin
                in_valid = 1'b0;
                a = $urandom; b = $urandom; alu_op = 3'($urandom_range(0, 7));
            end
            if (out_valid) break;
            if (in_ready) rdy_in_busy = 1'b1;
        end
        check("timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("drop_valid", 64'(out_valid), 64'd0);
    endtask

    task automatic check_out(input string tag, input logic [W-1:0] r, input logic [W-1:0] h,
                             input logic z, input logic o);
        check({tag, "_res"},  64'(result),    64'(r));
        check({tag, "_hi"},   64'(result_hi), 64'(h));
        check({tag, "_zero"}, 64'(zero),      64'(z));
        check({tag, "_ovf"},  64'(overflow),  64'(o));
    endtask

    int lat;
    bit rdy;

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check_out("rst", '0, '0, 1'b0, 1'b0);
        rst_n = 1'b1;

        run_op(ALU_ADD, 32'h7FFF_FFFF, 32'd1, lat, rdy);
        check("add_lat", 64'(lat), 64'd1);
        check_out("add_ovf", 32'h8000_0000, '0, 1'b0, 1'b1);
        consume();

        run_op(ALU_ADD, 32'h8000_0000, 32'h8000_0000, lat, rdy);
        check_out("add_neg_ovf", 32'h0, '0, 1'b1, 1'b1);
        consume();

        run_op(ALU_SUB, 32'd5, 32'd5, lat, rdy);
        check_out("sub_eq", 32'h0, '0, 1'b1, 1'b0);
        consume();

        run_op(ALU_SUB, 32'h8000_0000, 32'd1, lat, rdy);
        check_out("sub_ovf", 32'h7FFF_FFFF, '0, 1'b0, 1'b1);
        consume();

        run_op(ALU_SLT, 32'hFFFF_FFFF, 32'd1, lat, rdy);
        check_out("slt", 32'd1, '0, 1'b0, 1'b0);
        consume();

        run_op(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, lat, rdy);
        check_out("sltu", 32'd0, '0, 1'b1, 1'b0);
        consume();

        run_op(ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00, lat, rdy);
        check("and_res", 64'(result), 64'h00F0_1200);
        consume();

        run_op(ALU_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, rdy);
        check("mulu_lat", 64'(lat), 64'd33);
        check("mulu_busy_rdy", 64'(rdy), 64'd0);
        check_out("mulu_max", 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0);
        consume();

        run_op(ALU_MULU, 32'd6, 32'd7, lat, rdy);
        check_out("mulu_small", 32'd42, 32'd0, 1'b0, 1'b0);
        consume();

        run_op(ALU_DIVU, 32'd100, 32'd7, lat, rdy);
        check("divu_lat", 64'(lat), 64'd33);
        check_out("divu", 32'd14, 32'd2, 1'b0, 1'b0);
        consume();

        run_op(ALU_DIVU, 32'd9, 32'd0, lat, rdy);
        check("div0_lat", 64'(lat), 64'd1);
        check_out("div0", 32'hFFFF_FFFF, 32'd9, 1'b0, 1'b0);
        consume();

        // Backpressure: held result, ignored request, then same-edge accept.
        run_op(ALU_OR, 32'h0000_00F0, 32'h0000_000F, lat, rdy);
        alu_op = ALU_ADD; a = 32'd1; b = 32'd2; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_res", 64'(result), 64'h0000_00FF);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        #1 check("bp_release_rdy", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        check("bp_next_valid", 64'(out_valid), 64'd1);
        check("bp_next_res", 64'(result), 64'd3);
        consume();

        // Back-to-back single-cycle ops, one result per cycle.
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1;
        alu_op = ALU_ADD; a = 32'd10; b = 32'd20;
        @(posedge clk); @(negedge clk);
        check("b2b_1", 64'(result), 64'd30);
        alu_op = ALU_OR; a = 32'h0000_0100; b = 32'h0000_0001;
        @(posedge clk); @(negedge clk);
        check("b2b_2", 64'(result), 64'h101);
        check("b2b_2_valid", 64'(out_valid), 64'd1);
        alu_op = ALU_SUB; a = 32'd3; b = 32'd4;
        @(posedge clk); @(negedge clk);
        check("b2b_3", 64'(result), 64'hFFFF_FFFF);
        in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        check("b2b_drop", 64'(out_valid), 64'd0);

        // Reset in the middle of a multiply.
        @(negedge clk);
        alu_op = ALU_MULU; a = 32'd123; b = 32'd456; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("mid_busy_rdy", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check_out("mid_rst", '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(ALU_ADD, 32'd2, 32'd3, lat, rdy);
        check("post_rst_lat", 64'(lat), 64'd1);
        check_out("post_rst_add", 32'd5, '0, 1'b0, 1'b0);
        consume();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
